// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned radix-2 restoring divider.
// Computes quotient = floor(dividend/divisor) and remainder = dividend mod divisor
// over WIDTH iteration cycles. One operation is in flight at a time.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous reset, active-low
//   start     - sample operands and begin an operation (ignored while Busy)
//   dividend  - numerator, sampled on accepted start
//   divisor   - denominator, sampled on accepted start
//   quotient  - result, held until the next operation completes
//   remainder - remainder, held likewise
//   div_zero  - asserted with Ready when the sampled divisor was zero
//   Busy      - high while iterating (exactly WIDTH cycles)
//   Ready     - high from completion until the next accepted start or reset
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             Busy,
  output logic             Ready
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   rem_q;     // partial remainder, one bit wider than the operands
  logic [WIDTH-1:0] qsh_q;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   rem_sh_d;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] qsh_d;
  logic             ge_d;
  logic             accept_d;

  // One restoring step on the current partial remainder.
  // With a zero divisor every step subtracts nothing and sets the quotient bit,
  // so the natural result is all-ones quotient and remainder = dividend.
  always_comb begin
    rem_sh_d = {rem_q[WIDTH-1:0], qsh_q[WIDTH-1]};
    ge_d     = (rem_sh_d >= {1'b0, dvsr_q});
    rem_d    = ge_d ? (rem_sh_d - {1'b0, dvsr_q}) : rem_sh_d;
    qsh_d    = {qsh_q[WIDTH-2:0], ge_d};
    accept_d = start && (state_q != ST_BUSY);
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      qsh_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      Busy      <= 1'b0;
      Ready     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_d) begin
            state_q  <= ST_BUSY;
            rem_q    <= '0;
            qsh_q    <= dividend;
            dvsr_q   <= divisor;
            cnt_q    <= '0;
            div_zero <= 1'b0;
            Busy     <= 1'b1;
            Ready    <= 1'b0;
          end
        end
        ST_BUSY: begin
          rem_q <= rem_d;
          qsh_q <= qsh_d;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Last step: publish results and wrap the counter.
            state_q   <= ST_DONE;
            cnt_q     <= '0;
            quotient  <= qsh_d;
            remainder <= rem_d[WIDTH-1:0];
            div_zero  <= (dvsr_q == '0);
            Busy      <= 1'b0;
            Ready     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          Busy    <= 1'b0;
          Ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: scoreboard of expected results, one task per scenario.
module tb_seq_divider;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         Busy;
  logic         Ready;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .Busy(Busy), .Ready(Ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive a one-cycle start (called just after a falling edge); returns after the next falling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Count cycles Busy stays high, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({quotient, remainder, div_zero, Busy, Ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got q=%0d r=%0d dz=%b busy=%b rdy=%b, want all 0",
               quotient, remainder, div_zero, Busy, Ready);
    end
    rst = 1'b1;
    dividend = 16'd55; divisor = 16'd5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({quotient, remainder, div_zero, Busy, Ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got q=%0d r=%0d dz=%b busy=%b rdy=%b, want all 0",
               quotient, remainder, div_zero, Busy, Ready);
    end
  endtask

  task automatic test_nominal();
    int   cyc;
    exp_t e;
    issue(16'd2095, 16'd100, 1'b1);
    n_cmp++;
    if (Busy !== 1'b1 || Ready !== 1'b0 || quotient !== '0) begin
      n_bad++;
      $display("FAIL nom_start: got busy=%b rdy=%b q=%0d, want busy=1 rdy=0 q=0", Busy, Ready, quotient);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != 16) begin
      n_bad++;
      $display("FAIL nom_busy_cycles: got %0d, want 16", cyc);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
      n_bad++;
      $display("FAIL nom_result: got q=%0d r=%0d dz=%b rdy=%b, want q=%0d r=%0d dz=%b rdy=1",
               quotient, remainder, div_zero, Ready, e.q, e.r, e.dz);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({quotient, remainder, Ready, Busy} !== {16'd20, 16'd95, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL nom_hold: got q=%0d r=%0d rdy=%b busy=%b, want q=20 r=95 rdy=1 busy=0",
               quotient, remainder, Ready, Busy);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] as [6];
    logic [W-1:0] bs [6];
    int   cyc;
    exp_t e;
    as = '{16'd65535, 16'd0, 16'd100, 16'd1, 16'd40000, 16'd12345};
    bs = '{16'd1,     16'd7, 16'd65535, 16'd2, 16'd40000, 16'd999};
    foreach (as[i]) begin
      issue(as[i], bs[i], 1'b1);
      wait_done(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL ext_sb_empty[%0d]: got empty queue, want entry", i);
      end else begin
        e = sb.pop_front();
        if (cyc != 16 || {quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
          n_bad++;
          $display("FAIL ext[%0d] %0d/%0d: got q=%0d r=%0d dz=%b rdy=%b cyc=%0d, want q=%0d r=%0d dz=%b rdy=1 cyc=16",
                   i, as[i], bs[i], quotient, remainder, div_zero, Ready, cyc, e.q, e.r, e.dz);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    int   cyc;
    exp_t e;
    issue(16'd1234, 16'd0, 1'b1);
    n_cmp++;
    if (div_zero !== 1'b0 || Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_start: got dz=%b rdy=%b, want dz=0 rdy=0", div_zero, Ready);
    end
    wait_done(cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 16 || {quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
      n_bad++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%b rdy=%b cyc=%0d, want q=%h r=%0d dz=1 rdy=1 cyc=16",
               quotient, remainder, div_zero, Ready, cyc, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    exp_t e;
    issue(16'd1000, 16'd10, 1'b1);
    repeat (4) @(negedge clk);
    issue(16'd9, 16'd3, 1'b0);           // arrives while Busy: must be ignored
    wait_done(cyc);
    n_cmp++;
    if (cyc != 11) begin
      n_bad++;
      $display("FAIL busy_no_restart: got %0d remaining busy cycles, want 11", cyc);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
      n_bad++;
      $display("FAIL busy_protect: got q=%0d r=%0d rdy=%b, want q=%0d r=%0d rdy=1",
               quotient, remainder, Ready, e.q, e.r);
    end
    issue(16'd9, 16'd3, 1'b1);           // accepted in DONE
    n_cmp++;
    if (Ready !== 1'b0 || Busy !== 1'b1 || quotient !== 16'd100) begin
      n_bad++;
      $display("FAIL b2b_accept: got rdy=%b busy=%b q=%0d, want rdy=0 busy=1 q=100", Ready, Busy, quotient);
    end
    wait_done(cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 16 || {quotient, remainder, Ready} !== {e.q, e.r, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_result: got q=%0d r=%0d rdy=%b cyc=%0d, want q=%0d r=%0d rdy=1 cyc=16",
               quotient, remainder, Ready, cyc, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    exp_t e;
    issue(16'd500, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({Busy, Ready, quotient, remainder, div_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b rdy=%b q=%0d r=%0d dz=%b, want all 0",
               Busy, Ready, quotient, remainder, div_zero);
    end
    rst = 1'b1;
    @(negedge clk);
    issue(16'd500, 16'd7, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc != 16 || {quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_fresh: got q=%0d r=%0d rdy=%b cyc=%0d, want q=%0d r=%0d rdy=1 cyc=16",
               quotient, remainder, Ready, cyc, e.q, e.r);
    end
  endtask

  task automatic test_random();
    int           cyc;
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom);
      b = (i == 3) ? W'(0) : W'($urandom_range(1, (i < 4) ? 300 : 65535));
      issue(a, b, 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (cyc != 16 || {quotient, remainder, div_zero, Ready} !== {e.q, e.r, e.dz, 1'b1}) begin
        n_bad++;
        $display("FAIL rnd[%0d] %0d/%0d: got q=%0d r=%0d dz=%b cyc=%0d, want q=%0d r=%0d dz=%b cyc=16",
                 i, a, b, quotient, remainder, div_zero, cyc, e.q, e.r, e.dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
